// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions for the fetch stage: NOP encoding, fetch exception codes,
// the fetch-entry record carried to decode, and the fetch state encoding.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [3:0]  EXC_MISALIGNED   = 4'd0;
  localparam logic [3:0]  EXC_ACCESS_FAULT = 4'd1;
  localparam int          QUEUE_DEPTH      = 2;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        exc_en;
    logic [3:0]  exc_code;
    logic [63:0] exc_val;
  } fetch_entry_t;

  localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_EXC_WAIT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response, redirect input and
// the decode-side handshake with the head entry.
interface fetch_unit_if;

  logic [63:0] pc_addr;
  logic [31:0] imem_instr;
  logic        imem_exc_en;
  logic [3:0]  imem_exc_code;
  logic [63:0] imem_exc_val;
  logic        redirect_en;
  logic [63:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        if_exc_en;
  logic [3:0]  if_exc_code;
  logic [63:0] if_exc_val;

  modport master (
    output pc_addr, if_valid, if_pc, if_instr, if_exc_en, if_exc_code, if_exc_val,
    input  imem_instr, imem_exc_en, imem_exc_code, imem_exc_val,
    input  redirect_en, redirect_pc, if_ready
  );

  modport slave (
    input  pc_addr, if_valid, if_pc, if_instr, if_exc_en, if_exc_code, if_exc_val,
    output imem_instr, imem_exc_en, imem_exc_code, imem_exc_val,
    output redirect_en, redirect_pc, if_ready
  );

endinterface

// File: rtl/fetch_unit_queue.sv
// Two-entry fetch queue (module fetch_queue) with enqueue, dequeue and flush.
// Flush drops every entry; enqueue into a full queue is accepted only with a dequeue.
module fetch_queue
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         enq_en,
  input  fetch_entry_t enq_data,
  input  logic         deq_en,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       do_enq, do_deq;

  assign do_deq = deq_en && (count_q != 2'd0);
  assign do_enq = enq_en && !flush && ((count_q != 2'd2) || do_deq);

  genvar gi;
  generate
    for (gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_entry
      fetch_entry_t entry_q, entry_d;

      always_comb begin
        entry_d = entry_q;
        if (do_enq && (wr_ptr_q == 1'(gi)))
          entry_d = enq_data;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) entry_q <= '0;
        else     entry_q <= entry_d;
      end
    end
  endgenerate

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_enq) wr_ptr_d = ~wr_ptr_q;
      if (do_deq) rd_ptr_d = ~rd_ptr_q;
      case ({do_enq, do_deq})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = rd_ptr_q ? g_entry[1].entry_q : g_entry[0].entry_q;
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: PC register and RUN/EXC_WAIT control feeding a 2-entry queue to decode.
// Optional FETCH_MISALIGN_CHECK_EN raises a local misaligned-fetch exception.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);

  logic [63:0]  pc_q, pc_d;
  fetch_state_e state_q, state_d;
  fetch_entry_t enq_entry, head;
  logic [1:0]   count;
  logic         enq_en, flush, transfer, misaligned, not_empty;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misaligned = (pc_q[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign not_empty = (count != 2'd0);
  assign transfer  = not_empty && bus.if_ready;

  always_comb begin
    pc_d               = pc_q;
    state_d            = state_q;
    enq_en             = 1'b0;
    flush              = 1'b0;
    enq_entry.pc       = pc_q;
    enq_entry.instr    = bus.imem_instr;
    enq_entry.exc_en   = bus.imem_exc_en;
    enq_entry.exc_code = bus.imem_exc_code;
    enq_entry.exc_val  = bus.imem_exc_val;

    if (bus.redirect_en) begin
      pc_d    = bus.redirect_pc;
      flush   = 1'b1;
      state_d = ST_RUN;
    end else if ((state_q == ST_RUN) && ((count != 2'd2) || transfer)) begin
      enq_en = 1'b1;
      if (misaligned) begin
        // Local fault takes precedence; whatever memory returned this cycle is ignored.
        enq_entry.instr    = NOP_INSTR;
        enq_entry.exc_en   = 1'b1;
        enq_entry.exc_code = EXC_MISALIGNED;
        enq_entry.exc_val  = pc_q;
        state_d            = ST_EXC_WAIT;
      end else if (bus.imem_exc_en) begin
        enq_entry.instr = NOP_INSTR;
        state_d         = ST_EXC_WAIT;
      end else begin
        pc_d = pc_q + 64'd4;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      state_q <= ST_RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  fetch_queue u_queue (
    .clk      (clk),
    .rst      (rst),
    .enq_en   (enq_en),
    .enq_data (enq_entry),
    .deq_en   (transfer),
    .flush    (flush),
    .head     (head),
    .count    (count)
  );

  assign bus.pc_addr     = pc_q;
  assign bus.if_valid    = not_empty;
  assign bus.if_pc       = not_empty ? head.pc       : 64'h0;
  assign bus.if_instr    = not_empty ? head.instr    : NOP_INSTR;
  assign bus.if_exc_en   = not_empty ? head.exc_en   : 1'b0;
  assign bus.if_exc_code = not_empty ? head.exc_code : 4'd0;
  assign bus.if_exc_val  = not_empty ? head.exc_val  : 64'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, backpressure, redirects, faults, misalignment, PC wrap.
module tb_fetch_unit;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(64'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Combinational instruction memory: recognisable word derived from the address.
  assign bus.imem_instr = {8'hA5, bus.pc_addr[23:0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.if_ready      = 1'b1;
    bus.redirect_en   = 1'b0;
    bus.redirect_pc   = 64'h0;
    bus.imem_exc_en   = 1'b0;
    bus.imem_exc_code = 4'd0;
    bus.imem_exc_val  = 64'h0;

    tick(); tick();
    chk("rst_pc_addr",  bus.pc_addr,  64'h0);
    chk("rst_valid",    64'(bus.if_valid), 64'h0);
    chk("rst_if_pc",    bus.if_pc,    64'h0);
    chk("rst_if_instr", 64'(bus.if_instr), 64'h13);
    chk("rst_exc_en",   64'(bus.if_exc_en), 64'h0);
    rst = 1'b0;
    tick();
    chk("seq_pc_addr_4", bus.pc_addr, 64'h4);
    chk("seq_if_pc_0",   bus.if_pc,   64'h0);
    chk("seq_if_instr_0", 64'(bus.if_instr), 64'hA500_0000);
    tick();
    chk("seq_pc_addr_8", bus.pc_addr, 64'h8);
    chk("seq_if_pc_4",   bus.if_pc,   64'h4);

    // Reset mid-operation drops queued entries; then hold backpressure.
    rst = 1'b1;
    #3;
    chk("midrst_valid",   64'(bus.if_valid), 64'h0);
    chk("midrst_pc_addr", bus.pc_addr, 64'h0);
    bus.if_ready = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("bp_pc_hold",  bus.pc_addr, 64'h8);
    chk("bp_valid",    64'(bus.if_valid), 64'h1);
    chk("bp_head_0",   bus.if_pc,   64'h0);
    chk("bp_count",    64'(dut.u_queue.count), 64'h2);
    bus.if_ready = 1'b1;
    tick();
    chk("bp_head_4",   bus.if_pc,   64'h4);
    chk("bp_pc_12",    bus.pc_addr, 64'hC);
    tick();
    chk("bp_head_8",   bus.if_pc,   64'h8);
    chk("bp_instr_8",  64'(bus.if_instr), 64'hA500_0008);

    // Redirect while full with decode stalled.
    bus.if_ready    = 1'b0;
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 64'h100;
    tick();
    chk("redir_valid",   64'(bus.if_valid), 64'h0);
    chk("redir_pc_addr", bus.pc_addr, 64'h100);
    bus.redirect_en = 1'b0;
    tick();
    chk("redir_if_pc",    bus.if_pc, 64'h100);
    chk("redir_if_instr", 64'(bus.if_instr), 64'hA500_0100);
    tick();
    chk("full_head_hold", bus.if_pc, 64'h100);

    // Transfer and redirect on the same edge.
    bus.if_ready    = 1'b1;
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 64'h2000;
    tick();
    chk("xfer_redir_valid", 64'(bus.if_valid), 64'h0);
    chk("xfer_redir_pc",    bus.pc_addr, 64'h2000);
    bus.redirect_en = 1'b0;

    // Access fault from memory on the first fetch after redirect.
    bus.if_ready      = 1'b0;
    bus.imem_exc_en   = 1'b1;
    bus.imem_exc_code = 4'd1;
    bus.imem_exc_val  = 64'h2000;
    tick();
    chk("flt_valid",    64'(bus.if_valid), 64'h1);
    chk("flt_if_pc",    bus.if_pc, 64'h2000);
    chk("flt_exc_en",   64'(bus.if_exc_en), 64'h1);
    chk("flt_exc_code", 64'(bus.if_exc_code), 64'h1);
    chk("flt_exc_val",  bus.if_exc_val, 64'h2000);
    chk("flt_instr",    64'(bus.if_instr), 64'h13);
    chk("flt_pc_hold",  bus.pc_addr, 64'h2000);
    bus.imem_exc_en   = 1'b0;
    bus.imem_exc_code = 4'd0;
    bus.imem_exc_val  = 64'h0;
    bus.if_ready      = 1'b1;
    tick();
    chk("flt_drained", 64'(bus.if_valid), 64'h0);
    tick();
    chk("flt_no_fetch", 64'(bus.if_valid), 64'h0);
    chk("flt_pc_stuck", bus.pc_addr, 64'h2000);
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 64'h0;
    tick();
    bus.redirect_en = 1'b0;
    bus.if_ready    = 1'b0;
    tick();
    chk("flt_resume_pc",  bus.if_pc, 64'h0);
    chk("flt_resume_exc", 64'(bus.if_exc_en), 64'h0);

    // Misaligned redirect target.
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 64'h102;
    tick();
    chk("mis_pc_addr", bus.pc_addr, 64'h102);
    bus.redirect_en = 1'b0;
    tick();
    chk("mis_if_pc", bus.if_pc, 64'h102);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis_exc_en",   64'(bus.if_exc_en), 64'h1);
    chk("mis_exc_code", 64'(bus.if_exc_code), 64'h0);
    chk("mis_exc_val",  bus.if_exc_val, 64'h102);
    chk("mis_instr",    64'(bus.if_instr), 64'h13);
    chk("mis_pc_hold",  bus.pc_addr, 64'h102);
`else
    chk("mis_exc_en",   64'(bus.if_exc_en), 64'h0);
    chk("mis_instr",    64'(bus.if_instr), 64'hA500_0102);
    chk("mis_pc_next",  bus.pc_addr, 64'h106);
`endif

    // PC wraps modulo 2^64.
    bus.if_ready    = 1'b1;
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    bus.redirect_en = 1'b0;
    tick();
    chk("wrap_pc_addr",  bus.pc_addr, 64'h0);
    chk("wrap_if_pc",    bus.if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_if_instr", 64'(bus.if_instr), 64'hA5FF_FFFC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, PC loaded at reset.
REQ-002 SHALL have port clk, input, 1, single clock, all state on rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port pc_addr, output, 64, fetch address to instruction memory, equal to PC register.
REQ-005 SHALL have port imem_instr, input, 32, instruction returned combinationally for pc_addr.
REQ-006 SHALL have ports imem_exc_en (1), imem_exc_code (4), imem_exc_val (64), inputs, memory-side fetch exception.
REQ-007 SHALL have ports redirect_en (1), redirect_pc (64), inputs, branch/trap redirect.
REQ-008 SHALL have ports if_valid (1) output and if_ready (1) input, decode handshake.
REQ-009 SHALL have outputs if_pc (64), if_instr (32), if_exc_en (1), if_exc_code (4), if_exc_val (64), head entry to decode.

Function
REQ-010 SHALL hold a 2-entry FIFO of {pc, instr, exc_en, exc_code, exc_val}; if_* outputs show head, if_valid = count!=0.
REQ-011 SHALL define transfer as if_valid && if_ready; head dequeued on that edge.
REQ-012 SHALL, in state RUN with no redirect, enqueue {pc_addr, imem_instr, imem_exc_*} and advance PC by 4 when count<2 or a transfer occurs this cycle (zero-bubble at full).
REQ-013 SHALL, when full with no transfer, hold PC and enqueue nothing.
REQ-014 SHALL wrap PC modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC + 4 = 0).
REQ-015 SHALL, on enqueue with imem_exc_en=1, store instr 32'h00000013 with exception fields, hold PC, and enter state EXC_WAIT.
REQ-016 SHALL, in EXC_WAIT, enqueue nothing and hold PC until redirect; queued entries still drain.
REQ-017 SHALL, on redirect_en=1, load PC with redirect_pc, discard all FIFO entries not transferred this cycle, enqueue nothing, and enter RUN; a transfer in the same cycle counts as consumed.
REQ-018 SHALL give redirect priority over enqueue, full-stall and EXC_WAIT.
REQ-019 SHALL present the first post-redirect instruction on if_* one cycle after redirect (fetch latency 1 cycle, memory combinational).

Reset
REQ-020 SHALL, on rst asserted, asynchronously set PC=RESET_PC, count=0, FIFO pointers=0, state RUN, if_valid=0.
REQ-021 SHALL drive if_pc=0, if_instr=32'h00000013, if_exc_en=0, if_exc_code=0, if_exc_val=0 while count=0.
REQ-022 SHALL enqueue nothing while rst is high; first enqueue on first edge after deassertion, from RESET_PC.
REQ-023 SHALL abandon any in-flight FIFO content on reset mid-operation with no partial entry surviving.

Configuration
REQ-024 SHALL, with FETCH_MISALIGN_CHECK_EN defined, check pc_addr[1:0]!=0 before enqueue and instead enqueue a local exception (code 4'd0, val=pc_addr, instr NOP), enter EXC_WAIT, ignoring imem_* that cycle.
REQ-025 SHALL, without FETCH_MISALIGN_CHECK_EN, pass misaligned PCs to memory unchecked and rely only on imem_exc_*.

Structure
REQ-026 SHALL take NOP encoding 32'h00000013, exception codes (0 misaligned, 1 access fault) and the fetch-entry struct width from the shared CPU package.
REQ-027 SHALL implement the FIFO as sub-module fetch_queue (2 entries, enqueue/dequeue/flush, count); state machine and PC stay in fetch_unit.

Verification
REQ-028 SHALL test reset: RESET_PC=0, if_ready=1 -> pc_addr 0,4,8 on successive cycles, if_pc lags by 1 cycle.
REQ-029 SHALL test backpressure: if_ready=0 for 5 cycles -> count saturates at 2, PC holds at 8, release -> entries 0,4 then 8 in order, no loss/duplication.
REQ-030 SHALL test redirect while full: redirect_pc=64'h100 with if_ready=0 -> both entries dropped, next if_pc=64'h100.
REQ-031 SHALL test fault: imem_exc_en=1, code 1, val 64'h2000 at pc 64'h2000 -> entry if_exc_en=1, if_instr=32'h00000013, no further fetch until redirect to 64'h0.
REQ-032 SHALL test misalignment with macro defined: redirect_pc=64'h102 -> if_exc_code=0, if_exc_val=64'h102; without macro, pc_addr=64'h102 issued.
REQ-033 SHALL test simultaneous transfer and redirect: head consumed, second entry discarded, next if_pc=redirect_pc.
